// File: rtl/logo_overlay.sv
// logo_overlay: alpha-blends an on-chip logo bitmap into a programmable rectangle of 4:2:2 video, 3-clk latency.
// Build option: define LOGO_LEGAL_CLIP_EN to clamp blended pixels to legal video range (Y 64..940, C 64..960).
module logo_overlay #(
    parameter int LOGO_W = 64,
    parameter int LOGO_H = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [19:0]       data_in,
    input  logic [2:0]        HVF_in,
    input  logic              logo_en,
    input  logic [11:0]       logo_x,
    input  logic [10:0]       logo_y,
    input  logic              logo_wr_en,
    input  logic [ADDR_W-1:0] logo_wr_addr,
    input  logic [23:0]       logo_wr_data,
    output logic [19:0]       data_out,
    output logic [2:0]        HVF_out,
    output logic              in_logo
);
    localparam int XB    = $clog2(LOGO_W);
    localparam int YB    = $clog2(LOGO_H);
    localparam int DEPTH = LOGO_W * LOGO_H;
    localparam logic [12:0] W_M1 = 13'(LOGO_W - 1);
    localparam logic [11:0] H_M1 = 12'(LOGO_H - 1);

    function automatic logic [9:0] blend10(input logic [9:0] lg, input logic [9:0] vd, input logic [4:0] w);
        logic [14:0] acc;
        acc = 15'(lg) * 15'(w) + 15'(vd) * 15'(5'd16 - w);
        return acc[13:4];
    endfunction

`ifdef LOGO_LEGAL_CLIP_EN
    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        logic [9:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction
`endif

    logic [2:0]        r_hvf_prev;
    logic [11:0]       r_px;
    logic [10:0]       r_ln;
    logic              r_en_sh;
    logic [11:0]       r_x_sh;
    logic [10:0]       r_y_sh;

    logic [19:0]       r_s1_data;
    logic [2:0]        r_s1_hvf;
    logic              r_s1_win;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [19:0]       r_s2_data;
    logic [2:0]        r_s2_hvf;
    logic              r_s2_win;
    logic [23:0]       r_mem_q;
    logic [23:0]       r_mem [DEPTH];

    logic              w_h_fall;
    logic              w_h_rise;
    logic              w_v_fall;
    logic              w_v_rise;
    logic [11:0]       w_px;
    logic [12:0]       w_x_end;
    logic [11:0]       w_y_end;
    logic              w_win;
    logic [11:0]       w_dx;
    logic [10:0]       w_dy;
    logic [ADDR_W-1:0] w_addr;
    logic [4:0]        w_w;
    logic [9:0]        w_bl_y;
    logic [9:0]        w_bl_c;

    assign w_h_fall = r_hvf_prev[0] & ~HVF_in[0];
    assign w_h_rise = ~r_hvf_prev[0] & HVF_in[0];
    assign w_v_fall = r_hvf_prev[1] & ~HVF_in[1];
    assign w_v_rise = ~r_hvf_prev[1] & HVF_in[1];

    // Position of the pixel currently on data_in and its window/address.
    always_comb begin
        w_px = r_px;
        if (w_h_fall) begin
            w_px = 12'd0;
        end else begin
            w_px = r_px;
        end
        w_x_end = {1'b0, r_x_sh} + W_M1;
        w_y_end = {1'b0, r_y_sh} + H_M1;
        w_win   = r_en_sh && (HVF_in[1:0] == 2'b00)
                  && (w_px >= r_x_sh) && ({1'b0, w_px} <= w_x_end)
                  && (r_ln >= r_y_sh) && ({1'b0, r_ln} <= w_y_end);
        w_dx    = w_px - r_x_sh;
        w_dy    = r_ln - r_y_sh;
        w_addr  = ADDR_W'({w_dy[YB-1:0], w_dx[XB-1:0]});
    end

    // Pixel/line counters, timing edge history and field-synchronous shadow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hvf_prev <= 3'b011;
            r_px       <= 12'd0;
            r_ln       <= 11'd0;
            r_en_sh    <= 1'b0;
            r_x_sh     <= 12'd0;
            r_y_sh     <= 11'd0;
        end else begin
            r_hvf_prev <= HVF_in;
            if (!HVF_in[0]) begin
                r_px <= (w_px == 12'hFFF) ? w_px : w_px + 12'd1;
            end
            if (w_v_fall) begin
                r_ln <= 11'd0;
            end else if (w_h_rise && !HVF_in[1] && (r_ln != 11'h7FF)) begin
                r_ln <= r_ln + 11'd1;
            end
            // Sampled only at the start of V blanking so a field never tears.
            if (w_v_rise) begin
                r_en_sh <= logo_en;
                r_x_sh  <= {logo_x[11:1], 1'b0};
                r_y_sh  <= logo_y;
            end
        end
    end

    // Logo memory: contents deliberately not reset; read returns old data on collision.
    always_ff @(posedge clk) begin
        if (logo_wr_en) begin
            r_mem[logo_wr_addr] <= logo_wr_data;
        end
        r_mem_q <= r_mem[r_s1_addr];
    end

    // S1/S2 pipeline registers carrying video alongside the memory access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_data <= 20'd0;
            r_s1_hvf  <= 3'b011;
            r_s1_win  <= 1'b0;
            r_s1_addr <= '0;
            r_s2_data <= 20'd0;
            r_s2_hvf  <= 3'b011;
            r_s2_win  <= 1'b0;
        end else begin
            r_s1_data <= data_in;
            r_s1_hvf  <= HVF_in;
            r_s1_win  <= w_win;
            r_s1_addr <= w_addr;
            r_s2_data <= r_s1_data;
            r_s2_hvf  <= r_s1_hvf;
            r_s2_win  <= r_s1_win;
        end
    end

    // Blend of the S2 logo word with S2 video; alpha 15 means fully opaque.
    always_comb begin
        w_w    = (r_mem_q[3:0] == 4'hF) ? 5'd16 : {1'b0, r_mem_q[3:0]};
        w_bl_y = blend10(r_mem_q[23:14], r_s2_data[19:10], w_w);
        w_bl_c = blend10(r_mem_q[13:4], r_s2_data[9:0], w_w);
`ifdef LOGO_LEGAL_CLIP_EN
        w_bl_y = clamp10(w_bl_y, 10'd64, 10'd940);
        w_bl_c = clamp10(w_bl_c, 10'd64, 10'd960);
`endif
    end

    // S3 output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= 20'd0;
            HVF_out  <= 3'b011;
            in_logo  <= 1'b0;
        end else begin
            data_out <= r_s2_win ? {w_bl_y, w_bl_c} : r_s2_data;
            HVF_out  <= r_s2_hvf;
            in_logo  <= r_s2_win;
        end
    end
endmodule

// File: tb/tb_logo_overlay.sv
// Scoreboard bench for logo_overlay: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_logo_overlay;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] data_in;
    logic [2:0]  HVF_in;
    logic        logo_en;
    logic [11:0] logo_x;
    logic [10:0] logo_y;
    logic        logo_wr_en;
    logic [10:0] logo_wr_addr;
    logic [23:0] logo_wr_data;
    logic [19:0] data_out;
    logic [2:0]  HVF_out;
    logic        in_logo;

    typedef struct {
        int          due;
        logic [19:0] d;
        logic [2:0]  h;
        logic        il;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        m_en = 1'b0;
    logic [11:0] m_x = 12'd0;
    logic [10:0] m_y = 11'd0;

    logo_overlay #(.LOGO_W(64), .LOGO_H(32), .ADDR_W(11)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .HVF_in(HVF_in),
        .logo_en(logo_en), .logo_x(logo_x), .logo_y(logo_y),
        .logo_wr_en(logo_wr_en), .logo_wr_addr(logo_wr_addr), .logo_wr_data(logo_wr_data),
        .data_out(data_out), .HVF_out(HVF_out), .in_logo(in_logo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the DUT presents one pixel; compare against the oldest due expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.due != cyc || data_out !== e.d || HVF_out !== e.h || in_logo !== e.il) begin
                n_err++;
                $display("FAIL pixel due=%0d cyc=%0d: got data=%h hvf=%b in_logo=%b, expected data=%h hvf=%b in_logo=%b",
                         e.due, cyc, data_out, HVF_out, in_logo, e.d, e.h, e.il);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [19:0] d, input logic [2:0] h, input logic [19:0] ed, input logic eil);
        @(posedge clk);
        #1;
        data_in = d;
        HVF_in  = h;
        q.push_back('{cyc + 3, ed, h, eil});
    endtask

    task automatic fill(input logic [9:0] y, input logic [9:0] c, input logic [3:0] a);
        logic [19:0] d;
        for (int i = 0; i < 2048; i++) begin
            d = 20'($urandom);
            step(d, 3'b011, d, 1'b0);
            logo_wr_en   = 1'b1;
            logo_wr_addr = 11'(i);
            logo_wr_data = {y, c, a};
        end
        d = 20'($urandom);
        step(d, 3'b011, d, 1'b0);
        logo_wr_en = 1'b0;
    endtask

    // Empty field: V falls then rises, so the shadow registers capture the current configuration.
    task automatic gen_blank();
        logic [19:0] d;
        for (int i = 0; i < 2; i++) begin
            d = 20'($urandom);
            step(d, 3'b001, d, 1'b0);
        end
        m_en = logo_en;
        m_x  = {logo_x[11:1], 1'b0};
        m_y  = logo_y;
        for (int i = 0; i < 4; i++) begin
            d = 20'($urandom);
            step(d, 3'b011, d, 1'b0);
        end
    endtask

    task automatic gen_field(input int w, input int nl, input logic [9:0] vy, input logic [9:0] vc,
                             input logic rnd, input logic [9:0] ey, input logic [9:0] ec,
                             input logic bconst, input int chg_ln, input logic [11:0] new_x);
        logic [19:0] d;
        logic [19:0] ed;
        logic        inw;
        for (int ln = 0; ln < nl; ln++) begin
            if (ln == chg_ln) logo_x = new_x;
            for (int i = 0; i < 4; i++) begin
                d = 20'($urandom);
                step(d, 3'b001, d, 1'b0);
            end
            for (int px = 0; px < w; px++) begin
                d   = rnd ? 20'($urandom) : {vy, vc};
                inw = m_en && (px >= int'(m_x)) && (px < int'(m_x) + 64)
                      && (ln >= int'(m_y)) && (ln < int'(m_y) + 32);
                ed  = (inw && bconst) ? {ey, ec} : d;
                step(d, 3'b000, ed, inw);
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        data_in      = 20'd0;
        HVF_in       = 3'b011;
        logo_en      = 1'b0;
        logo_x       = 12'd0;
        logo_y       = 11'd0;
        logo_wr_en   = 1'b0;
        logo_wr_addr = 11'd0;
        logo_wr_data = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset HVF_out", 32'(HVF_out), 32'h3);
        chk("reset in_logo", 32'(in_logo), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Overlay disabled: pure passthrough
        gen_blank();
        gen_field(64, 6, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0, -1, 12'd0);

        // Opaque logo at (100,10)
        fill(10'h3AC, 10'h200, 4'd15);
        logo_en = 1'b1; logo_x = 12'd100; logo_y = 11'd10;
        gen_blank();
        gen_field(170, 44, 10'h040, 10'h180, 1'b0, 10'h3AC, 10'h200, 1'b1, -1, 12'd0);

        // Half alpha
        fill(10'h200, 10'h200, 4'd8);
        logo_x = 12'd0; logo_y = 11'd0;
        gen_blank();
        gen_field(70, 2, 10'h100, 10'h100, 1'b0, 10'h180, 10'h180, 1'b1, -1, 12'd0);

        // Transparent logo: video unchanged, in_logo still set
        fill(10'h3FF, 10'h3FF, 4'd0);
        gen_blank();
        gen_field(70, 2, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0, -1, 12'd0);

        // Window past right edge, odd x forced even
        fill(10'h3AC, 10'h200, 4'd15);
        logo_x = 12'd1891;
        gen_blank();
        gen_field(1920, 2, 10'd0, 10'd0, 1'b1, 10'h3AC, 10'h200, 1'b1, -1, 12'd0);

        // Mid-field x change only applies after the next V blanking edge
        logo_x = 12'd0;
        gen_blank();
        gen_field(80, 3, 10'd0, 10'd0, 1'b1, 10'h3AC, 10'h200, 1'b1, 1, 12'd10);
        gen_blank();
        gen_field(80, 2, 10'd0, 10'd0, 1'b1, 10'h3AC, 10'h200, 1'b1, -1, 12'd0);

        // Extreme logo values
        fill(10'h3FF, 10'h000, 4'd15);
        gen_blank();
`ifdef LOGO_LEGAL_CLIP_EN
        gen_field(70, 2, 10'd0, 10'd0, 1'b1, 10'd940, 10'd64, 1'b1, -1, 12'd0);
`else
        gen_field(70, 2, 10'd0, 10'd0, 1'b1, 10'h3FF, 10'h000, 1'b1, -1, 12'd0);
`endif

        // Reset mid-line
        gen_field(20, 1, 10'd0, 10'd0, 1'b1, 10'h3FF, 10'h000, 1'b1, -1, 12'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        q.delete();
        m_en = 1'b0;
        #1;
        chk("midline reset data_out", 32'(data_out), 32'h0);
        chk("midline reset HVF_out", 32'(HVF_out), 32'h3);
        chk("midline reset in_logo", 32'(in_logo), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        gen_field(30, 2, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0, -1, 12'd0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/logo_overlay.md
Name: logo_overlay

Overview:
- Downstream of the line-alignment stage; consumes its reference-timed 20-bit 4:2:2 video and HVF timing.
- Alpha-blends a small on-chip logo bitmap into a programmable rectangle of the active picture.
- Passes blanking and all other pixels through unchanged.
- Fixed-latency pipeline; output timing is the input timing delayed by the same amount.

Parameters:
- LOGO_W, 64, logo width in pixels; even, power of two.
- LOGO_H, 32, logo height in lines; power of two.
- ADDR_W, 11, logo memory address width; equals log2(LOGO_W*LOGO_H).

Ports:
- clk  in  1  video reference clock; all logic in this domain.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  20  video; [19:10] Y, [9:0] Cb/Cr alternating.
- HVF_in  in  3  [0] H blanking, [1] V blanking, [2] field; 1 = blanking.
- logo_en  in  1  overlay enable request.
- logo_x  in  12  left pixel of the logo window; LSB ignored, forced even.
- logo_y  in  11  top active line of the window, counted within the field.
- logo_wr_en  in  1  logo memory write strobe.
- logo_wr_addr  in  ADDR_W  write address; row*LOGO_W + col.
- logo_wr_data  in  24  [23:14] Y, [13:4] C, [3:0] alpha.
- data_out  out  20  blended video.
- HVF_out  out  3  HVF_in delayed by 3 cycles.
- in_logo  out  1  high when data_out is a pixel inside the logo window.

Behaviour:
- Reset values: data_out=0, HVF_out=3'b011, in_logo=0. Counters, shadow registers and pipeline valid bits are cleared.
- A reset mid-line drives the outputs to reset values immediately. Counting restarts at the next H falling edge.
- Latency: exactly 3 clk from data_in/HVF_in to data_out/HVF_out, for every pixel, blanking included.
- Pixel counter px (12b):
  - Cleared to 0 on an HVF_in[0] 1->0 transition.
  - Increments each active cycle; holds during H blanking.
  - Saturates at 4095.
- Line counter ln (11b):
  - Cleared to 0 on an HVF_in[1] 1->0 transition.
  - Increments on each HVF_in[0] 0->1 transition while HVF_in[1]=0.
  - Saturates at 2047.
- Shadow registers: logo_en, logo_x (LSB forced 0) and logo_y are sampled on each HVF_in[1] 0->1 transition (start of V blanking). Changes mid-field take effect only at the next field, so there is no tearing.
- Window test: win = en_s && HVF_in[1:0]==0 && px in [x_s, x_s+LOGO_W-1] && ln in [y_s, y_s+LOGO_H-1]. Use 13-bit sums; any part of the window beyond the line or field end is never hit, with no wrap-around.
- Pipeline:
  - S1: compute win and addr = (ln-y_s)*LOGO_W + (px-x_s).
  - S2: synchronous memory read; delay video and win alongside it.
  - S3: blend and register outputs.
- Blend:
  - Weight w = 16 if alpha==15, otherwise alpha.
  - Y = (Ylogo*w + Yvid*(16-w)) >> 4, with 15-bit intermediate and truncation.
  - C uses the same formula on the 10-bit chroma.
  - Result never exceeds 1023.
- Passthrough: when win=0, data_out is data_in delayed 3 cycles, bit-exact. Blanking is never modified.
- in_logo is win delayed to align with data_out.
- Memory:
  - LOGO_W*LOGO_H x 24, single write port and single read port, both on clk.
  - A write and read to the same address in the same cycle returns the old data.
  - Contents are not reset; software loads the memory before enabling.
- Chroma phase: because x_s is even, logo column 0 always lands on a Cb sample.

Optional Feature:
- Macro LOGO_LEGAL_CLIP_EN.
- When defined: on blended pixels only, the S3 result is clamped to Y 64..940 and C 64..960. This adds no latency. Passthrough pixels are unclamped.
- When undefined: there are no clamps and the blend result is output as is.

Test Plan:
- Reset asserted mid-line -> data_out=0 and HVF_out=3'b011 immediately. After release, the first active pixel appears 3 clk after the input, bit-exact.
- logo_en=0, 1920x1080 frame -> data_out equals data_in delayed 3 clk for every cycle and in_logo never asserts.
- Memory filled with alpha=15, Y=0x3AC, C=0x200; logo_x=100, logo_y=10; video Y=0x040 -> pixels px 100..163 on lines 10..41 output 0x3AC/0x200, and px 99 and 164 are unchanged.
- alpha=8, Ylogo=0x200, Yvid=0x100 -> Y out 0x180. alpha=0 -> video unchanged with in_logo=1.
- logo_x=1890 -> only px 1890..1919 are blended and the next line is unaffected. logo_x changed mid-field -> the window moves only after the next V blanking edge.
- With LOGO_LEGAL_CLIP_EN defined: alpha=15, Ylogo=0x3FF, Clogo=0x000 -> output Y=940, C=64. Undefined -> 1023/0.
